// File: rtl/mod_sub_serial_pkg.sv
// Shared field-arithmetic package.
//   N_FE         : field element width in bits
//   FE_P         : modulus 2^255 - 19
//   fe_t         : field element type
//   msub_state_t : serial modular subtractor sequencing states
package icarus_pkg;

    localparam int unsigned N_FE = 256;

    localparam logic [N_FE-1:0] FE_P =
        256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;

    typedef logic [N_FE-1:0] fe_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } msub_state_t;

endpackage

// File: rtl/mod_sub_serial_if.sv
// Operand/result handshake bundle for the serial modular subtractor.
//   in_valid/in_ready   : operand handshake (a, b)
//   out_valid/out_ready : result handshake (res)
//   busy                : subtractor is working on an operation
// master = requester side, slave = subtractor side.
interface mod_sub_serial_if #(
    parameter int unsigned N = icarus_pkg::N_FE
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] res;
    logic         busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, res, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, res, busy
    );
endinterface

// File: rtl/mod_sub_serial_addsub.sv
// W-bit limb adder/subtractor with carry chaining.
//   ctrl : 1 = a - b - cin (cin/cout are borrows), 0 = a + b + cin (carries)
//   a, b : limb operands
//   cin  : incoming carry or borrow
//   sum  : limb result
//   cout : outgoing carry or borrow
module limb_addsub #(
    parameter int unsigned W = 32
) (
    input  logic         ctrl,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    logic [W:0] full;

    // Subtraction is a + ~b + ~borrow_in; the adder carry-out is then ~borrow_out.
    always_comb begin
        full = {1'b0, a} + {1'b0, b ^ {W{ctrl}}} + {{W{1'b0}}, cin ^ ctrl};
        sum  = full[W-1:0];
        cout = full[W] ^ ctrl;
    end
endmodule

// File: rtl/mod_sub_serial.sv
// Sequential modular subtractor: res = (a - b) mod P, one W-bit limb per cycle.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of mod_sub_serial_if (in_valid/in_ready/a/b,
//              out_valid/out_ready/res, busy)
// Flow: IDLE -> SUB (K limbs) -> FIX (K limbs, only on underflow) -> DONE -> IDLE.
module mod_sub_serial
    import icarus_pkg::*;
#(
    parameter int unsigned N = N_FE,
    parameter int unsigned W = 32,
    parameter logic [N-1:0] P = FE_P
) (
    input  logic                clk,
    input  logic                rst,
    mod_sub_serial_if.slave     bus
);
    localparam int unsigned K    = N / W;
    localparam int unsigned IDXW = (K > 1) ? $clog2(K) : 1;

    msub_state_t     state_q, state_d;
    logic [N-1:0]    a_q, b_q, res_q;
    logic [IDXW-1:0] idx_q;
    logic            carry_q;
    logic            out_valid_q;

    logic            ctrl;
    logic [W-1:0]    op_a, op_b, sum;
    logic            cout;
    logic            last_limb;

    assign last_limb = (idx_q == IDXW'(K - 1));

    // One adder serves both phases: SUB takes a/b limbs, FIX takes res/P limbs.
    always_comb begin
        ctrl = (state_q == SUB);
        op_a = ctrl ? a_q[idx_q*W +: W] : res_q[idx_q*W +: W];
        op_b = ctrl ? b_q[idx_q*W +: W] : P[idx_q*W +: W];
    end

    limb_addsub #(.W(W)) u_addsub (
        .ctrl (ctrl),
        .a    (op_a),
        .b    (op_b),
        .cin  (carry_q),
        .sum  (sum),
        .cout (cout)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.in_valid)                state_d = SUB;
            SUB:  if (last_limb)                   state_d = cout ? FIX : DONE;
            FIX:  if (last_limb)                   state_d = DONE;
            DONE: if (out_valid_q && bus.out_ready) state_d = IDLE;
            default:                               state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        idx_q   <= '0;
                        carry_q <= 1'b0;
                    end
                end
                SUB, FIX: begin
                    res_q[idx_q*W +: W] <= sum;
                    idx_q               <= last_limb ? '0 : idx_q + 1'b1;
                    // Borrow must not leak into FIX; FIX's final carry is dropped too.
                    carry_q             <= last_limb ? 1'b0 : cout;
                end
                DONE: begin
                    // out_valid rises one cycle after entering DONE and falls on the accept.
                    out_valid_q <= !(out_valid_q && bus.out_ready);
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.res       = res_q;
    assign bus.busy      = (state_q == SUB) || (state_q == FIX);
endmodule

// File: tb/tb_mod_sub_serial.sv
module tb_mod_sub_serial;
    localparam logic [255:0] PMOD =
        256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;
    localparam int TIMEOUT = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mod_sub_serial_if #(.N(256)) bus ();

    mod_sub_serial dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [255:0] a;
        logic [255:0] b;
        logic [255:0] exp_res;
        int           exp_lat;
    } vec_t;

    vec_t tbl[5];

    task automatic check_fe(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: modular difference from plain arithmetic on reduced operands.
    function automatic logic [255:0] ref_sub(input logic [255:0] a, input logic [255:0] b);
        if (a >= b) return a - b;
        return a + (PMOD - b);
    endfunction

    function automatic logic [255:0] rand_fe();
        logic [255:0] v;
        v = '0;
        if ($urandom_range(0, 3) == 0) begin
            v[31:0] = $urandom_range(0, 100);
        end else begin
            for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
            v[255] = 1'b0;
            if (v >= PMOD) v = v - PMOD;
        end
        return v;
    endfunction

    // Present operands for one edge; caller sits #1 after an edge in IDLE.
    task automatic start_op(input logic [255:0] a, input logic [255:0] b);
        check_int("in_ready_before_accept", int'(bus.in_ready), 1);
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Count edges from the accept edge until out_valid is seen.
    task automatic wait_result(output logic [255:0] r, output int lat);
        lat = -1;
        for (int c = 1; c <= TIMEOUT; c++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                lat = c;
                break;
            end
        end
        if (lat < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: got no out_valid within %0d cycles required out_valid=1", TIMEOUT);
        end
        r = bus.res;
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check_int("out_valid_drop", int'(bus.out_valid), 0);
        check_int("in_ready_after_done", int'(bus.in_ready), 1);
    endtask

    task automatic run_op(input string name, input logic [255:0] a, input logic [255:0] b,
                          input logic [255:0] exp_res, input int exp_lat);
        logic [255:0] r;
        int           lat;
        start_op(a, b);
        wait_result(r, lat);
        check_fe({name, "_res"}, r, exp_res);
        check_int({name, "_lat"}, lat, exp_lat);
        release_result();
    endtask

    initial begin
        logic [255:0] r, ra, rb, held;
        int           lat;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;

        tbl[0] = '{256'd10, 256'd3, 256'd7, 9};
        tbl[1] = '{256'd3, 256'd10,
                   256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffe6, 17};
        tbl[2] = '{PMOD - 256'd1, PMOD - 256'd1, 256'd0, 9};
        tbl[3] = '{256'd0, PMOD - 256'd1, 256'd1, 17};
        tbl[4] = '{256'd1 << 200, 256'd1, (256'd1 << 200) - 256'd1, 9};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_int("rst_in_ready", int'(bus.in_ready), 1);
        check_int("rst_out_valid", int'(bus.out_valid), 0);
        check_int("rst_busy", int'(bus.busy), 0);
        check_fe("rst_res", bus.res, '0);

        for (int i = 0; i < 5; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].exp_res, tbl[i].exp_lat);
        end

        // Back-pressure in DONE with new operands offered.
        start_op(256'd10, 256'd3);
        check_int("busy_in_sub", int'(bus.busy), 1);
        wait_result(held, lat);
        check_fe("bp_res", held, 256'd7);
        bus.a        = 256'd5;
        bus.b        = 256'd1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_fe("bp_res_stable", bus.res, 256'd7);
            check_int("bp_out_valid", int'(bus.out_valid), 1);
            check_int("bp_in_ready", int'(bus.in_ready), 0);
            check_int("bp_busy", int'(bus.busy), 0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check_int("bp_release_out_valid", int'(bus.out_valid), 0);
        check_int("bp_release_busy", int'(bus.busy), 0);
        check_int("bp_release_in_ready", int'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check_int("bp_accept_busy", int'(bus.busy), 1);
        wait_result(r, lat);
        check_fe("bp_next_res", r, 256'd4);
        check_int("bp_next_lat", lat, 9);
        release_result();

        // Reset mid-SUB at limb 3.
        start_op(256'd12345, 256'd99999);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_int("midsub_rst_in_ready", int'(bus.in_ready), 1);
        check_int("midsub_rst_out_valid", int'(bus.out_valid), 0);
        check_int("midsub_rst_busy", int'(bus.busy), 0);
        check_fe("midsub_rst_res", bus.res, '0);
        run_op("after_rst", 256'd1 << 200, 256'd1, (256'd1 << 200) - 256'd1, 9);

        // Reset in DONE while stalled.
        start_op(256'd3, 256'd10);
        wait_result(r, lat);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_int("done_rst_out_valid", int'(bus.out_valid), 0);
        check_int("done_rst_in_ready", int'(bus.in_ready), 1);
        check_fe("done_rst_res", bus.res, '0);

        // Random reduced pairs against the reference model.
        for (int i = 0; i < 500; i++) begin
            ra = rand_fe();
            rb = ($urandom_range(0, 15) == 0) ? ra : rand_fe();
            run_op("rand", ra, rb, ref_sub(ra, rb), (ra < rb) ? 17 : 9);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
